// File: rtl/blit_engine.sv
// Rectangle blitter: copies a w x h sprite from source memory to the frame
// buffer program port, one pixel per cycle, with mirroring, stride, colour
// key, screen clipping, abort and a written-pixel counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; config inputs are latched on start
// S_RUN   | issuing one source read per cycle in raster order
// S_DRAIN | reads done, waiting for the last SRC_LATENCY pixels to land
module blit_engine #(
   parameter int SRC_AW      = 18,
   parameter int DATA_W      = 16,
   parameter int COORD_W     = 10,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int SRC_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [COORD_W-1:0]     dest_x,
   input  logic [COORD_W-1:0]     dest_y,
   input  logic [COORD_W-1:0]     width,
   input  logic [COORD_W-1:0]     height,
   input  logic [SRC_AW-1:0]      src_base,
   input  logic [SRC_AW-1:0]      src_stride,
   input  logic                   flip_x,
   input  logic                   flip_y,
   input  logic                   key_en,
   input  logic [DATA_W-1:0]      key_color,
   output logic                   busy,
   output logic                   done,
   output logic [2*COORD_W-1:0]   pix_count,
   output logic [SRC_AW-1:0]      src_addr,
   output logic                   src_rd,
   input  logic [DATA_W-1:0]      src_data,
   output logic [COORD_W-1:0]     program_x,
   output logic [COORD_W-1:0]     program_y,
   output logic [DATA_W-1:0]      program_data,
   output logic                   program_write
);

   localparam int DRAIN_W = (SRC_LATENCY > 1) ? $clog2(SRC_LATENCY) : 1;
   localparam int PIX_W   = 2*COORD_W;

   localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
   localparam logic [COORD_W-1:0] C_ZERO = '0;
   localparam logic [DRAIN_W-1:0] D_ONE  = DRAIN_W'(1);
   localparam logic [PIX_W-1:0]   P_ONE  = PIX_W'(1);
   localparam logic [COORD_W:0]   X_LIM  = (COORD_W+1)'(SCREEN_W);
   localparam logic [COORD_W:0]   Y_LIM  = (COORD_W+1)'(SCREEN_H);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t state, state_nxt;
   logic   done_nxt;

   logic [COORD_W-1:0] cfg_dest_x, cfg_dest_y, cfg_width, cfg_height;
   logic [SRC_AW-1:0]  cfg_src_base, cfg_src_stride;
   logic               cfg_flip_x, cfg_flip_y, cfg_key_en;
   logic [DATA_W-1:0]  cfg_key_color;

   logic [COORD_W-1:0] cur_col, cur_row, col_nxt, row_nxt;
   logic               last_issue;
   logic               n_zero;
   logic [DRAIN_W-1:0] drain_cnt;

   // coordinates of the pixel whose read is on src_addr this cycle
   logic [COORD_W:0]   issue_x, issue_y;

   logic [SRC_LATENCY-1:0] pipe_v;
   logic [COORD_W:0]       pipe_x [SRC_LATENCY];
   logic [COORD_W:0]       pipe_y [SRC_LATENCY];

   logic out_valid, key_hit, on_screen;

   // Source address of sprite pixel (col,row) after optional mirroring.
   function automatic logic [SRC_AW-1:0] pixel_addr(
      input logic [SRC_AW-1:0]  base,
      input logic [SRC_AW-1:0]  stride,
      input logic [COORD_W-1:0] w,
      input logic [COORD_W-1:0] h,
      input logic               fx,
      input logic               fy,
      input logic [COORD_W-1:0] col,
      input logic [COORD_W-1:0] row
   );
      logic [COORD_W-1:0] sc, sr;
      sc = fx ? (w - C_ONE - col) : col;
      sr = fy ? (h - C_ONE - row) : row;
      return base + SRC_AW'(sr) * stride + SRC_AW'(sc);
   endfunction

   assign n_zero = (width == C_ZERO) || (height == C_ZERO);
   assign busy   = (state != S_IDLE);

   // raster walk: next column/row and detection of the final pixel
   always_comb begin
      col_nxt    = cur_col + C_ONE;
      row_nxt    = cur_row;
      last_issue = 1'b0;
      if (cur_col == cfg_width - C_ONE) begin
         col_nxt = C_ZERO;
         row_nxt = cur_row + C_ONE;
         if (cur_row == cfg_height - C_ONE)
            last_issue = 1'b1;
      end
   end

   // state register and done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
      end
   end

   // next-state logic; abort wins in RUN/DRAIN, start wins in IDLE
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               if (n_zero) done_nxt  = 1'b1;
               else        state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (abort)           state_nxt = S_IDLE;
            else if (last_issue) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (drain_cnt == '0) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // config latch and read issue: src_addr/src_rd and issue coordinates
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_dest_x     <= '0;
         cfg_dest_y     <= '0;
         cfg_width      <= '0;
         cfg_height     <= '0;
         cfg_src_base   <= '0;
         cfg_src_stride <= '0;
         cfg_flip_x     <= 1'b0;
         cfg_flip_y     <= 1'b0;
         cfg_key_en     <= 1'b0;
         cfg_key_color  <= '0;
         cur_col        <= '0;
         cur_row        <= '0;
         issue_x        <= '0;
         issue_y        <= '0;
         src_addr       <= '0;
         src_rd         <= 1'b0;
         drain_cnt      <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  cfg_dest_x     <= dest_x;
                  cfg_dest_y     <= dest_y;
                  cfg_width      <= width;
                  cfg_height     <= height;
                  cfg_src_base   <= src_base;
                  cfg_src_stride <= src_stride;
                  cfg_flip_x     <= flip_x;
                  cfg_flip_y     <= flip_y;
                  cfg_key_en     <= key_en;
                  cfg_key_color  <= key_color;
                  cur_col        <= '0;
                  cur_row        <= '0;
                  issue_x        <= {1'b0, dest_x};
                  issue_y        <= {1'b0, dest_y};
                  if (!n_zero) begin
                     src_rd   <= 1'b1;
                     src_addr <= pixel_addr(src_base, src_stride, width, height,
                                            flip_x, flip_y, C_ZERO, C_ZERO);
                  end
               end
            end
            S_RUN: begin
               if (abort || last_issue) begin
                  src_rd    <= 1'b0;
                  drain_cnt <= DRAIN_W'(SRC_LATENCY - 1);
               end else begin
                  cur_col  <= col_nxt;
                  cur_row  <= row_nxt;
                  issue_x  <= {1'b0, cfg_dest_x} + {1'b0, col_nxt};
                  issue_y  <= {1'b0, cfg_dest_y} + {1'b0, row_nxt};
                  src_addr <= pixel_addr(cfg_src_base, cfg_src_stride, cfg_width, cfg_height,
                                         cfg_flip_x, cfg_flip_y, col_nxt, row_nxt);
               end
            end
            S_DRAIN: begin
               if (drain_cnt != '0)
                  drain_cnt <= drain_cnt - D_ONE;
            end
            default: ;
         endcase
      end
   end

   // valid/coordinate delay line matching the source read latency
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_v <= '0;
         for (int i = 0; i < SRC_LATENCY; i++) begin
            pipe_x[i] <= '0;
            pipe_y[i] <= '0;
         end
      end else begin
         pipe_x[0] <= issue_x;
         pipe_y[0] <= issue_y;
         for (int i = 1; i < SRC_LATENCY; i++) begin
            pipe_x[i] <= pipe_x[i-1];
            pipe_y[i] <= pipe_y[i-1];
         end
         if (abort && busy) begin
            pipe_v <= '0;
         end else begin
            pipe_v[0] <= src_rd;
            for (int i = 1; i < SRC_LATENCY; i++)
               pipe_v[i] <= pipe_v[i-1];
         end
      end
   end

   assign out_valid     = pipe_v[SRC_LATENCY-1];
   assign key_hit       = cfg_key_en && (src_data == cfg_key_color);
   assign on_screen     = (pipe_x[SRC_LATENCY-1] < X_LIM) && (pipe_y[SRC_LATENCY-1] < Y_LIM);
   assign program_write = out_valid && !key_hit && on_screen;
   assign program_x     = pipe_x[SRC_LATENCY-1][COORD_W-1:0];
   assign program_y     = pipe_y[SRC_LATENCY-1][COORD_W-1:0];
   assign program_data  = out_valid ? src_data : '0;

   // written-pixel counter, cleared by an accepted start, saturating
   always_ff @(posedge clk) begin
      if (reset)
         pix_count <= '0;
      else if (state == S_IDLE && start)
         pix_count <= '0;
      else if (program_write && pix_count != '1)
         pix_count <= pix_count + P_ONE;
   end

endmodule

// File: tb/tb_blit_engine.sv
// Bench for blit_engine: table of rectangle jobs checked through an
// address/write scoreboard, plus hand sequences for abort and reset.
module tb_blit_engine;

   localparam int AW = 18;
   localparam int DW = 16;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start1 = 1'b0, start2 = 1'b0, abort = 1'b0;
   logic [CW-1:0] dest_x = '0, dest_y = '0, width = '0, height = '0;
   logic [AW-1:0] src_base = '0, src_stride = '0;
   logic          flip_x = 1'b0, flip_y = 1'b0, key_en = 1'b0;
   logic [DW-1:0] key_color = '0;

   logic            u1_busy, u1_done, u1_src_rd, u1_program_write;
   logic [2*CW-1:0] u1_pix_count;
   logic [AW-1:0]   u1_src_addr;
   logic [DW-1:0]   u1_src_data, u1_program_data;
   logic [CW-1:0]   u1_program_x, u1_program_y;

   logic            u2_busy, u2_done, u2_src_rd, u2_program_write;
   logic [2*CW-1:0] u2_pix_count;
   logic [AW-1:0]   u2_src_addr;
   logic [DW-1:0]   u2_src_data, u2_program_data;
   logic [CW-1:0]   u2_program_x, u2_program_y;

   logic [DW-1:0] mem [256];
   logic [DW-1:0] s2_a, s2_b;

   int n_tests = 0;
   int n_fail  = 0;
   int cycle_no = 0;
   int base_cyc = 0;
   bit mon_en = 1'b0;

   typedef struct packed {int addr; int cyc;} addr_exp_t;
   typedef struct packed {int x; int y; logic [15:0] data; int cyc;} wr_exp_t;
   addr_exp_t aq[$];
   wr_exp_t   wq[$];

   typedef struct packed {
      int dx; int dy; int w; int h; int base; int stride;
      bit fx; bit fy; bit ke; logic [15:0] key;
      int pat; int exp_writes; int exp_done;
   } vec_t;
   vec_t vecs[9];

   blit_engine #(.SRC_LATENCY(1)) u1 (
      .clk(clk), .reset(reset), .start(start1), .abort(abort),
      .dest_x(dest_x), .dest_y(dest_y), .width(width), .height(height),
      .src_base(src_base), .src_stride(src_stride),
      .flip_x(flip_x), .flip_y(flip_y), .key_en(key_en), .key_color(key_color),
      .busy(u1_busy), .done(u1_done), .pix_count(u1_pix_count),
      .src_addr(u1_src_addr), .src_rd(u1_src_rd), .src_data(u1_src_data),
      .program_x(u1_program_x), .program_y(u1_program_y),
      .program_data(u1_program_data), .program_write(u1_program_write));

   blit_engine #(.SRC_LATENCY(3)) u2 (
      .clk(clk), .reset(reset), .start(start2), .abort(abort),
      .dest_x(dest_x), .dest_y(dest_y), .width(width), .height(height),
      .src_base(src_base), .src_stride(src_stride),
      .flip_x(flip_x), .flip_y(flip_y), .key_en(key_en), .key_color(key_color),
      .busy(u2_busy), .done(u2_done), .pix_count(u2_pix_count),
      .src_addr(u2_src_addr), .src_rd(u2_src_rd), .src_data(u2_src_data),
      .program_x(u2_program_x), .program_y(u2_program_y),
      .program_data(u2_program_data), .program_write(u2_program_write));

   always #5 clk = ~clk;

   always @(posedge clk) cycle_no <= cycle_no + 1;

   // source memory models: 1-cycle latency for u1, 3-cycle for u2
   always @(posedge clk) begin
      u1_src_data <= mem[u1_src_addr[7:0]];
      s2_a        <= mem[u2_src_addr[7:0]];
      s2_b        <= s2_a;
      u2_src_data <= s2_b;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // scoreboard: every u1 read and write is matched against the queues
   always @(negedge clk) begin
      addr_exp_t ae;
      wr_exp_t   we;
      int        rel;
      if (mon_en) begin
         rel = cycle_no - base_cyc;
         if (u1_src_rd) begin
            if (aq.size() == 0) chk("unexpected src_rd", 1, 0);
            else begin
               ae = aq.pop_front();
               chk("src_addr", 64'(u1_src_addr), 64'(ae.addr));
               chk("src_rd cycle", 64'(rel), 64'(ae.cyc));
            end
         end
         if (u1_program_write) begin
            if (wq.size() == 0) chk("unexpected program_write", 1, 0);
            else begin
               we = wq.pop_front();
               chk("program_x", 64'(u1_program_x), 64'(we.x));
               chk("program_y", 64'(u1_program_y), 64'(we.y));
               chk("program_data", 64'(u1_program_data), 64'(we.data));
               chk("write cycle", 64'(rel), 64'(we.cyc));
            end
         end
      end
   end

   task automatic fill_mem(input int pat);
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      if (pat == 1) begin
         mem[101] = 16'h07E0;
         mem[104] = 16'h07E0;
         mem[107] = 16'h07E0;
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int sc, sr, a, x, y, k, rel, done_cyc, busy_cnt, n;
      logic [15:0] d;
      @(negedge clk);
      fill_mem(v.pat);
      aq.delete();
      wq.delete();
      for (int r = 0; r < v.h; r++) begin
         for (int c = 0; c < v.w; c++) begin
            k  = r*v.w + c;
            sc = v.fx ? v.w-1-c : c;
            sr = v.fy ? v.h-1-r : r;
            a  = (v.base + sr*v.stride + sc) % (1 << AW);
            aq.push_back('{a, k+1});
            d = mem[a % 256];
            x = v.dx + c;
            y = v.dy + r;
            if (!(v.ke && d == v.key) && x < 640 && y < 480)
               wq.push_back('{x, y, d, k+2});
         end
      end
      dest_x = CW'(v.dx); dest_y = CW'(v.dy);
      width = CW'(v.w);   height = CW'(v.h);
      src_base = AW'(v.base); src_stride = AW'(v.stride);
      flip_x = v.fx; flip_y = v.fy; key_en = v.ke; key_color = v.key;
      start1 = 1'b1;
      base_cyc = cycle_no;
      mon_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      // scramble inputs; the running job must keep its latched config
      dest_x = dest_x ^ 10'h155; width = 10'd7; height = 10'd7;
      flip_x = ~flip_x; src_base = 18'h3; key_en = ~key_en; key_color = 16'hFFFF;
      done_cyc = 0;
      busy_cnt = 0;
      for (int i = 0; i < 60 && done_cyc == 0; i++) begin
         if (i > 0) @(negedge clk);
         rel = cycle_no - base_cyc;
         if (u1_busy) busy_cnt++;
         if (u1_done) done_cyc = rel;
      end
      n = v.w * v.h;
      chk($sformatf("v%0d done cycle", idx), 64'(done_cyc), 64'(v.exp_done));
      chk($sformatf("v%0d busy cycles", idx), 64'(busy_cnt), 64'((n > 0) ? n+1 : 0));
      chk($sformatf("v%0d pix_count", idx), 64'(u1_pix_count), 64'(v.exp_writes));
      chk($sformatf("v%0d busy at done", idx), 64'(u1_busy), 64'(0));
      @(negedge clk);
      chk($sformatf("v%0d done one cycle", idx), 64'(u1_done), 64'(0));
      chk($sformatf("v%0d pix_count hold", idx), 64'(u1_pix_count), 64'(v.exp_writes));
      chk($sformatf("v%0d missing reads", idx), 64'(aq.size()), 64'(0));
      chk($sformatf("v%0d missing writes", idx), 64'(wq.size()), 64'(0));
      mon_en = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      //            dx   dy  w  h base stride fx fy ke key       pat wr done
      vecs[0] = '{10,  20, 4, 2, 100, 4,  1'b0,1'b0,1'b0,16'h07E0, 0, 8, 10};
      vecs[1] = '{10,  20, 4, 2, 100, 4,  1'b1,1'b1,1'b0,16'h07E0, 0, 8, 10};
      vecs[2] = '{10,  20, 4, 2, 100, 4,  1'b0,1'b0,1'b1,16'h07E0, 1, 5, 10};
      vecs[3] = '{638, 479,4, 2, 100, 4,  1'b0,1'b0,1'b0,16'h07E0, 0, 2, 10};
      vecs[4] = '{10,  20, 0, 3, 100, 4,  1'b0,1'b0,1'b0,16'h07E0, 0, 0, 1};
      vecs[5] = '{0,   0,  3, 3, 5,   10, 1'b0,1'b1,1'b0,16'h07E0, 0, 9, 11};
      vecs[6] = '{639, 0,  1, 1, 200, 0,  1'b0,1'b0,1'b0,16'h07E0, 0, 1, 3};
      vecs[7] = '{600, 100,5, 1, 50,  7,  1'b1,1'b0,1'b1,16'h07E0, 1, 5, 7};
      vecs[8] = '{10,  20, 5, 0, 100, 4,  1'b0,1'b0,1'b0,16'h07E0, 0, 0, 1};

      fill_mem(0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", 64'(u1_busy), 0);
      chk("reset done", 64'(u1_done), 0);
      chk("reset src_rd", 64'(u1_src_rd), 0);
      chk("reset program_write", 64'(u1_program_write), 0);
      chk("reset pix_count", 64'(u1_pix_count), 0);
      chk("reset src_addr", 64'(u1_src_addr), 0);
      chk("reset program_x", 64'(u1_program_x), 0);
      chk("reset program_data", 64'(u1_program_data), 0);
      chk("reset u2 busy", 64'(u2_busy), 0);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // abort mid-RUN on the 3-cycle-latency instance, then start+abort in IDLE
      @(negedge clk);
      fill_mem(0);
      dest_x = 10'd5; dest_y = 10'd6; width = 10'd2; height = 10'd2;
      src_base = 18'd0; src_stride = 18'd2;
      flip_x = 1'b0; flip_y = 1'b0; key_en = 1'b0;
      start2 = 1'b1;
      base_cyc = cycle_no;
      @(posedge clk);
      for (int rel = 1; rel <= 10; rel++) begin
         @(negedge clk);
         if (rel == 1) begin
            start2 = 1'b0;
            chk("abort busy c1", 64'(u2_busy), 1);
         end
         if (rel == 3) begin
            chk("abort src_addr c3", 64'(u2_src_addr), 2);
            abort = 1'b1;
         end
         if (rel == 4) begin
            chk("abort busy c4", 64'(u2_busy), 0);
            chk("abort src_rd c4", 64'(u2_src_rd), 0);
            chk("abort pix_count c4", 64'(u2_pix_count), 0);
            start2 = 1'b1;
            width = 10'd1; height = 10'd1; src_base = 18'd3;
            dest_x = 10'd7; dest_y = 10'd8;
         end
         if (rel == 5) begin
            start2 = 1'b0;
            abort = 1'b0;
            chk("restart busy c5", 64'(u2_busy), 1);
            chk("restart src_rd c5", 64'(u2_src_rd), 1);
            chk("restart src_addr c5", 64'(u2_src_addr), 3);
         end
         if (rel >= 4 && rel <= 7)
            chk($sformatf("abort no write c%0d", rel), 64'(u2_program_write), 0);
         if (rel <= 8)
            chk($sformatf("abort no done c%0d", rel), 64'(u2_done), 0);
         if (rel == 8) begin
            chk("restart write c8", 64'(u2_program_write), 1);
            chk("restart x", 64'(u2_program_x), 7);
            chk("restart y", 64'(u2_program_y), 8);
            chk("restart data", 64'(u2_program_data), 64'h1003);
         end
         if (rel == 9) begin
            chk("restart done c9", 64'(u2_done), 1);
            chk("restart pix_count", 64'(u2_pix_count), 1);
            chk("restart busy c9", 64'(u2_busy), 0);
         end
      end

      // reset asserted in the middle of a run clears every output
      @(negedge clk);
      dest_x = 10'd10; dest_y = 10'd20; width = 10'd4; height = 10'd2;
      src_base = 18'd100; src_stride = 18'd4;
      flip_x = 1'b0; flip_y = 1'b0; key_en = 1'b0;
      start1 = 1'b1;
      base_cyc = cycle_no;
      @(posedge clk);
      for (int rel = 1; rel <= 6; rel++) begin
         @(negedge clk);
         if (rel == 1) start1 = 1'b0;
         if (rel == 4) begin
            chk("pre-reset pix_count", 64'(u1_pix_count), 2);
            reset = 1'b1;
         end
         if (rel == 5) begin
            chk("mid reset busy", 64'(u1_busy), 0);
            chk("mid reset done", 64'(u1_done), 0);
            chk("mid reset src_rd", 64'(u1_src_rd), 0);
            chk("mid reset src_addr", 64'(u1_src_addr), 0);
            chk("mid reset program_write", 64'(u1_program_write), 0);
            chk("mid reset pix_count", 64'(u1_pix_count), 0);
            chk("mid reset program_x", 64'(u1_program_x), 0);
            chk("mid reset program_y", 64'(u1_program_y), 0);
            chk("mid reset program_data", 64'(u1_program_data), 0);
            reset = 1'b0;
         end
         if (rel == 6) begin
            chk("post reset busy", 64'(u1_busy), 0);
            chk("post reset src_rd", 64'(u1_src_rd), 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
